// File: rtl/fhn_stim_sequencer_if.sv
// Host/core-facing signal bundle of the FitzHugh-Nagumo stimulus sequencer.
// The master modport drives configuration, control and v; the slave modport is the sequencer.
interface fhn_stim_sequencer_if #(
    parameter int W     = 16,
    parameter int DUR_W = 16,
    parameter int CNT_W = 8
);
    logic                    cfg_we;
    logic [1:0]              cfg_addr;
    logic signed [W-1:0]     cfg_amp;
    logic [DUR_W-1:0]        cfg_dur;
    logic [1:0]              cfg_last;
    logic                    start;
    logic                    abort;
    logic signed [W-1:0]     v_in;
    logic signed [W-1:0]     thresh_hi;
    logic signed [W-1:0]     thresh_lo;
    logic signed [W-1:0]     i_stim;
    logic                    core_rst;
    logic                    busy;
    logic                    done;
    logic [1:0]              phase_idx;
    logic                    spike;
    logic [CNT_W-1:0]        spike_cnt;

    modport master (
        output cfg_we, cfg_addr, cfg_amp, cfg_dur, cfg_last, start, abort,
               v_in, thresh_hi, thresh_lo,
        input  i_stim, core_rst, busy, done, phase_idx, spike, spike_cnt
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_amp, cfg_dur, cfg_last, start, abort,
               v_in, thresh_hi, thresh_lo,
        output i_stim, core_rst, busy, done, phase_idx, spike, spike_cnt
    );
endinterface

// File: rtl/fhn_stim_sequencer.sv
// Sequences the FHN neuron core: settle in reset, play a 4-entry (amplitude, duration)
// schedule on the stimulus input, and count hysteretic spikes on v while running.
module fhn_stim_sequencer #(
    parameter int W          = 16,
    parameter int FRC_BITS   = 12,
    parameter int DUR_W      = 16,
    parameter int CNT_W      = 8,
    parameter int SETTLE_CYC = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    fhn_stim_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN, S_DONE} state_t;

    localparam logic [DUR_W-1:0] SETTLE_LD = DUR_W'(SETTLE_CYC - 1);

    if (SETTLE_CYC < 1 || FRC_BITS >= W) begin : g_bad_param
        $error("fhn_stim_sequencer: SETTLE_CYC must be >= 1 and FRC_BITS < W");
    end

    state_t                r_state, w_state_nxt;
    logic [DUR_W-1:0]      r_cnt, w_cnt_nxt;
    logic [1:0]            r_phase, w_phase_nxt;
    logic [1:0]            r_last, w_last_nxt;
    logic signed [W-1:0]   r_amp [4];
    logic [DUR_W-1:0]      r_dur [4];
    logic                  r_armed;
    logic signed [W-1:0]   r_stim;
    logic                  r_core_rst, r_busy, r_done, r_spike;
    logic [CNT_W-1:0]      r_spike_cnt;
    logic                  w_start;

    // A programmed duration of 0 still occupies one cycle.
    function automatic logic [DUR_W-1:0] dur_load(input logic [DUR_W-1:0] d);
        return (d == '0) ? '0 : d - DUR_W'(1);
    endfunction

    assign w_start = (r_state == S_IDLE) && bus.start;

    // NOTE: every variable gets its default before the case, so no path leaves one unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        w_last_nxt  = r_last;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = SETTLE_LD;
                    w_phase_nxt = '0;
                    w_last_nxt  = bus.cfg_last;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_RUN;
                    w_phase_nxt = '0;
                    w_cnt_nxt   = dur_load(r_dur[0]);
                end else begin
                    w_cnt_nxt = r_cnt - DUR_W'(1);
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    if (r_phase == r_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_phase_nxt = r_phase + 2'd1;
                        w_cnt_nxt   = dur_load(r_dur[r_phase + 2'd1]);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - DUR_W'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_phase    <= '0;
            r_last     <= '0;
            r_stim     <= '0;
            r_core_rst <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_phase    <= w_phase_nxt;
            r_last     <= w_last_nxt;
            // Outputs are registered from the next state so they line up with it exactly.
            r_stim     <= (w_state_nxt == S_RUN) ? r_amp[w_phase_nxt] : '0;
            r_core_rst <= (w_state_nxt != S_RUN);
            r_busy     <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_RUN);
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

    // NOTE: the phase table is reset on purpose: a reset must leave a known, empty schedule.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                r_amp[i] <= '0;
                r_dur[i] <= '0;
            end
        end else if (bus.cfg_we && r_state == S_IDLE) begin
            r_amp[bus.cfg_addr] <= bus.cfg_amp;
            r_dur[bus.cfg_addr] <= bus.cfg_dur;
        end
    end

    // Hysteretic detector: a dip below thresh_lo arms, a rise to thresh_hi fires once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_armed     <= 1'b0;
            r_spike     <= 1'b0;
            r_spike_cnt <= '0;
        end else if (r_state == S_RUN) begin
            if (r_armed && bus.v_in >= bus.thresh_hi) begin
                r_spike <= 1'b1;
                r_armed <= 1'b0;
                if (r_spike_cnt != {CNT_W{1'b1}}) r_spike_cnt <= r_spike_cnt + CNT_W'(1);
            end else begin
                r_spike <= 1'b0;
                if (bus.v_in < bus.thresh_lo) r_armed <= 1'b1;
            end
        end else begin
            r_spike <= 1'b0;
            r_armed <= 1'b0;
            if (w_start) r_spike_cnt <= '0;
        end
    end

    assign bus.i_stim    = r_stim;
    assign bus.core_rst  = r_core_rst;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.phase_idx = r_phase;
    assign bus.spike     = r_spike;
    assign bus.spike_cnt = r_spike_cnt;

endmodule

// File: tb/tb_fhn_stim_sequencer.sv
// Self-checking bench for fhn_stim_sequencer: per-edge scoreboard runs built from segment
// tables, plus hand-written abort, spike, saturation and reset sequences.
module tb_fhn_stim_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fhn_stim_sequencer_if #(.W(16), .DUR_W(16), .CNT_W(8)) bus ();

    fhn_stim_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Segment of edges (relative to the start edge) with constant expected outputs.
    typedef struct {
        int first;
        int last;
        int stim;
        bit crst;
        bit busy;
        bit done;
        bit chk_ph;
        int ph;
    } vec_t;

    typedef struct {
        int                 edge_no;
        logic signed [15:0] stim;
        bit                 crst;
        bit                 busy;
        bit                 done;
        bit                 chk_ph;
        logic [1:0]         ph;
    } exp_t;

    typedef struct {
        int v;
        bit sp;
        int cnt;
    } sp_t;

    vec_t tab[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input int amp, input int dur);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_amp  = 16'(amp);
        bus.cfg_dur  = 16'(dur);
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic check_outs(input string name, input int stim, input bit crst,
                              input bit busy, input bit done);
        check(name, {45'b0, bus.i_stim, bus.core_rst, bus.busy, bus.done},
                    {45'b0, 16'(stim), crst, busy, done});
    endtask

    // Expand the segment table into per-edge expectations, start the run, compare every edge.
    task automatic run_sb(input string name, input logic [1:0] last);
        exp_t e;
        logic [1:0] aph;
        logic [1:0] eph;
        foreach (tab[i]) begin
            for (int k = tab[i].first; k <= tab[i].last; k++) begin
                e.edge_no = k;
                e.stim    = 16'(tab[i].stim);
                e.crst    = tab[i].crst;
                e.busy    = tab[i].busy;
                e.done    = tab[i].done;
                e.chk_ph  = tab[i].chk_ph;
                e.ph      = 2'(tab[i].ph);
                exp_q.push_back(e);
            end
        end
        bus.cfg_last = last;
        bus.start    = 1'b1;
        while (exp_q.size() > 0) begin
            tick();
            bus.start = 1'b0;
            e   = exp_q.pop_front();
            aph = e.chk_ph ? bus.phase_idx : 2'b0;
            eph = e.chk_ph ? e.ph : 2'b0;
            check($sformatf("%s@%0d", name, e.edge_no),
                  {34'b0, bus.i_stim, bus.core_rst, bus.busy, bus.done, aph, bus.spike, bus.spike_cnt},
                  {34'b0, e.stim, e.crst, e.busy, e.done, eph, 1'b0, 8'd0});
        end
    endtask

    task automatic check_reset_vals(input string name);
        check(name, {34'b0, bus.i_stim, bus.core_rst, bus.busy, bus.done, bus.phase_idx,
                     bus.spike, bus.spike_cnt},
                    {34'b0, 16'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0});
    endtask

    initial begin
        sp_t sp_tab[7];
        int  pulses;
        bit  done_seen;

        sp_tab[0] = '{-2000, 1'b0, 0};
        sp_tab[1] = '{ 3000, 1'b1, 1};
        sp_tab[2] = '{ 3000, 1'b0, 1};
        sp_tab[3] = '{  100, 1'b0, 1};
        sp_tab[4] = '{ 2500, 1'b0, 1};
        sp_tab[5] = '{-1500, 1'b0, 1};
        sp_tab[6] = '{ 2500, 1'b1, 2};

        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_amp = '0; bus.cfg_dur = '0;
        bus.cfg_last = '0; bus.start = 1'b0; bus.abort = 1'b0; bus.v_in = '0;
        bus.thresh_hi = 16'sd2048; bus.thresh_lo = -16'sd1024;

        #2 rst = 1'b0;
        #20;
        check_reset_vals("reset_values");
        tick();
        rst = 1'b1;
        tick();

        cfg_write(2'd0, 2048, 100);
        cfg_write(2'd1, 0, 200);
        cfg_write(2'd2, 4096, 100);
        cfg_write(2'd3, 2048, 100);

        // Run A: spikes, start-while-busy, cfg write while busy, abort at edge 50.
        bus.cfg_last = 2'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_outs("a_settle_e0", 0, 1'b1, 1'b1, 1'b0);
        repeat (10) tick();
        check_outs("a_run_e10", 2048, 1'b0, 1'b1, 1'b0);
        foreach (sp_tab[i]) begin
            bus.v_in = 16'(sp_tab[i].v);
            tick();
            check($sformatf("spike_seq[%0d]", i), {55'b0, bus.spike, bus.spike_cnt},
                  {55'b0, sp_tab[i].sp, 8'(sp_tab[i].cnt)});
        end
        bus.v_in = '0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check_outs("start_ignored_e19", 2048, 1'b0, 1'b1, 1'b0);
        check("start_ignored_phase", {62'b0, bus.phase_idx}, 64'd0);
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_amp = 16'sd777; bus.cfg_dur = 16'd5;
        tick();
        bus.cfg_we = 1'b0;
        repeat (30) tick();
        check_outs("a_run_e50", 2048, 1'b0, 1'b1, 1'b0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_outs("abort_e51", 0, 1'b1, 1'b0, 1'b0);
        check("abort_cnt_held", {56'b0, bus.spike_cnt}, 64'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("abort_no_done[%0d]", i), {62'b0, bus.done, bus.busy}, 64'd0);
        end
        check("abort_cnt_held_late", {56'b0, bus.spike_cnt}, 64'd2);

        // Run B: full schedule; entry 1 must still be 0/200 after the dropped busy write.
        tab = {};
        tab.push_back('{0,   9,   0,    1'b1, 1'b1, 1'b0, 1'b0, 0});
        tab.push_back('{10,  109, 2048, 1'b0, 1'b1, 1'b0, 1'b1, 0});
        tab.push_back('{110, 309, 0,    1'b0, 1'b1, 1'b0, 1'b1, 1});
        tab.push_back('{310, 409, 4096, 1'b0, 1'b1, 1'b0, 1'b1, 2});
        tab.push_back('{410, 509, 2048, 1'b0, 1'b1, 1'b0, 1'b1, 3});
        tab.push_back('{510, 510, 0,    1'b1, 1'b0, 1'b1, 1'b0, 0});
        tab.push_back('{511, 514, 0,    1'b1, 1'b0, 1'b0, 1'b0, 0});
        run_sb("full", 2'd3);

        // Zero-duration single phase.
        cfg_write(2'd0, -1024, 0);
        tab = {};
        tab.push_back('{0,  9,  0,     1'b1, 1'b1, 1'b0, 1'b0, 0});
        tab.push_back('{10, 10, -1024, 1'b0, 1'b1, 1'b0, 1'b1, 0});
        tab.push_back('{11, 11, 0,     1'b1, 1'b0, 1'b1, 1'b0, 0});
        tab.push_back('{12, 13, 0,     1'b1, 1'b0, 1'b0, 1'b0, 0});
        run_sb("zero_dur", 2'd0);

        // Saturation: 300 dip/peak pairs in one long phase.
        cfg_write(2'd0, 100, 1000);
        bus.cfg_last = 2'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            bus.v_in = -16'sd2000;
            tick();
            bus.v_in = 16'sd3000;
            tick();
            if (bus.spike) pulses++;
            if (i == 254) check("sat_reach_255", {56'b0, bus.spike_cnt}, 64'd255);
        end
        bus.v_in = '0;
        check("sat_pulses", 64'(pulses), 64'd300);
        check("sat_cnt_final", {56'b0, bus.spike_cnt}, 64'd255);
        done_seen = 1'b0;
        for (int n = 0; n < 2000 && !done_seen; n++) begin
            tick();
            done_seen = bus.done;
        end
        check("sat_done_seen", {63'b0, done_seen}, 64'd1);
        tick();

        // Asynchronous reset mid-run, then confirm the table was cleared.
        bus.cfg_last = 2'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (200) tick();
        #2 rst = 1'b0;
        #1;
        check_reset_vals("midrun_reset_async");
        tick();
        rst = 1'b1;
        tick();
        tab = {};
        tab.push_back('{0,  9,  0, 1'b1, 1'b1, 1'b0, 1'b0, 0});
        tab.push_back('{10, 10, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0});
        tab.push_back('{11, 11, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1});
        tab.push_back('{12, 12, 0, 1'b0, 1'b1, 1'b0, 1'b1, 2});
        tab.push_back('{13, 13, 0, 1'b0, 1'b1, 1'b0, 1'b1, 3});
        tab.push_back('{14, 14, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0});
        tab.push_back('{15, 16, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0});
        run_sb("cleared_tab", 2'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fhn_stim_sequencer.md
Name: fhn_stim_sequencer

Overview:
Controller that sequences the shared FitzHugh-Nagumo neuron core through a programmable stimulus schedule.
- Holds a 4-entry phase table of (amplitude, duration) pairs.
- Resets and settles the core, then drives the core's signed Q3.12 stimulus input phase by phase.
- Watches the core's membrane output v for spikes (hysteretic threshold) and counts them over the run.
- Replaces hand-written stimulus loops; sits between the host/config bus and the core.

Parameters:
W, 16, datapath width of stimulus and v (signed, FRC_BITS fractional bits)
FRC_BITS, 12, fractional bits of the fixed-point format (1.0 = 4096)
DUR_W, 16, phase duration counter width
CNT_W, 8, spike counter width (saturating)
SETTLE_CYC, 10, cycles the core is held in reset at run start (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
cfg_we  in  1  phase-table write strobe; ignored while busy
cfg_addr  in  2  phase-table entry index 0..3
cfg_amp  in  W  signed stimulus amplitude for the entry
cfg_dur  in  DUR_W  duration of the entry in cycles; 0 is treated as 1
cfg_last  in  2  index of the last phase to run; sampled on start
start  in  1  run request; sampled only in IDLE
abort  in  1  synchronous abort; acts in SETTLE/RUN
v_in  in  W  signed membrane value from the core
thresh_hi  in  W  signed spike threshold
thresh_lo  in  W  signed re-arm threshold (must be < thresh_hi)
i_stim  out  W  signed stimulus to the core, registered
core_rst  out  1  active-high reset to the core, registered
busy  out  1  high from the cycle after start is accepted until done/abort
done  out  1  one-cycle pulse at normal completion
phase_idx  out  2  currently applied phase
spike  out  1  one-cycle pulse per detected spike
spike_cnt  out  CNT_W  spikes detected in the current/last run

Behaviour:
- Async reset (rst=0):
  - state=IDLE, i_stim=0, core_rst=1, busy=0, done=0, phase_idx=0, spike=0, spike_cnt=0.
  - Phase table amps/durs=0; detector disarmed.
- IDLE: core_rst=1, i_stim=0.
  - On start=1 at edge k: latch cfg_last, clear spike_cnt, enter SETTLE; busy=1 from edge k.
  - cfg_we writes the table in IDLE only.
- SETTLE: core_rst=1, i_stim=0 for exactly SETTLE_CYC cycles (edges k..k+SETTLE_CYC-1), then RUN with phase_idx=0.
- RUN: core_rst=0, i_stim=amp[phase_idx].
  - Each phase lasts max(dur,1) cycles; the duration counter reloads at phase entry.
  - At phase end: if phase_idx==last, go to DONE; else phase_idx+1.
  - Phase switches are back-to-back, with no gap cycle.
- DONE (1 cycle): done=1, busy=0, i_stim=0, core_rst=1, then IDLE.
  - done edge = k + SETTLE_CYC + sum(max(dur_i,1)) for i in 0..last.
- abort in SETTLE/RUN: next edge goes to IDLE; i_stim=0, core_rst=1, busy=0, done stays 0, spike_cnt holds. abort in IDLE/DONE has no effect.
- start while busy or in DONE: ignored. start and abort together in IDLE: start wins.
- Spike detector, active in RUN only; uses signed comparisons on v_in:
  - armed is set when v_in < thresh_lo.
  - When armed and v_in >= thresh_hi: spike=1 on the next edge (1-cycle latency), armed is cleared, spike_cnt+1 saturating at 2^CNT_W-1.
  - Entering RUN clears armed, so the first spike requires a prior dip below thresh_lo.
  - Outside RUN: spike=0 and armed=0.
- cfg_we during busy: dropped; the table is unchanged.
- Reset mid-run: immediate return to reset values; the core is held in reset via core_rst=1.
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- Table {2048/100, 0/200, 4096/100, 2048/100}, cfg_last=3, start at edge 0:
  - core_rst=1 for edges 0-9.
  - i_stim=2048 for edges 10-109, 0 for 110-309, 4096 for 310-409, 2048 for 410-509.
  - done=1 at edge 510 only; busy low from 510.
- Zero-duration and single-phase run: dur[0]=0, amp[0]=-1024, cfg_last=0 -> i_stim=-1024 for exactly 1 cycle (edge 10), done at edge 11.
- Spike detection with thresh_hi=2048, thresh_lo=-1024:
  - v_in sequence -2000, 3000, 3000, 100, 2500 -> exactly one spike pulse (cycle after the first 3000), spike_cnt=1.
  - Follow with v_in=-1500, then 2500 -> second pulse, spike_cnt=2.
- Saturation: CNT_W=8, drive 300 dip/peak pairs -> spike_cnt stops at 255; spike pulses continue.
- abort at edge 50 of the first-scenario run -> i_stim=0, core_rst=1, busy=0 at edge 51; done never asserts; spike_cnt held. A new start restarts at SETTLE.
- Hazards:
  - rst=0 at edge 200 mid-run -> all outputs at reset values asynchronously, table cleared.
  - cfg_we during busy leaves the table unchanged (verified on the next run).
  - start during RUN is ignored.
